// File: rtl/flatten_frame_scheduler.sv
// Symbol-rate scheduler for the flattener: paces preamble, payload and gap symbols
// on a divide-by-32 load edge, and generates the 1M/2M clock enables.
module flatten_frame_scheduler #(
  parameter int unsigned    M        = 8,
  parameter int unsigned    PRE_LEN  = 8,
  parameter logic [M-1:0]   PRE_WORD = 'hA5,
  parameter int unsigned    PAY_LEN  = 64,
  parameter int unsigned    GAP_LEN  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         bypass_req,
  input  logic [M-1:0] src_data,
  input  logic         src_valid,
  output logic         src_ready,
  output logic         ce_1M,
  output logic         ce_2M,
  output logic         bypass,
  output logic [M-1:0] I,
  output logic         I_valid,
  input  logic         I_ready,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun
);

  localparam logic [7:0] PreLast = 8'(PRE_LEN - 1);
  localparam logic [7:0] PayLen  = 8'(PAY_LEN);
  localparam logic [7:0] GapLast = 8'(GAP_LEN - 1);

  typedef enum logic [1:0] {StIdle, StPre, StPay, StGap} state_e;

  state_e     state;
  logic [4:0] div_cnt;
  logic [7:0] cnt;
  logic       cur_counted;
  logic       load;
  logic [7:0] pay_done;
  logic       pay_slot;

  assign load = (div_cnt == 5'd31);

  // cnt holds counted symbols before the current one; cur_counted says whether
  // the symbol now on I (possibly a stall) counts toward the payload length.
  assign pay_done = cnt + {7'd0, cur_counted};

  // Load edges whose outgoing symbol is a payload slot.
  assign pay_slot = ((state == StPre) && (cnt == PreLast)) ||
                    ((state == StPay) && (pay_done != PayLen));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= 5'd0;
      state       <= StIdle;
      cnt         <= 8'd0;
      cur_counted <= 1'b0;
      ce_1M       <= 1'b0;
      ce_2M       <= 1'b0;
      bypass      <= 1'b0;
      I           <= '0;
      I_valid     <= 1'b0;
      src_ready   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      div_cnt    <= div_cnt + 5'd1;
      ce_1M      <= (div_cnt == 5'd0);
      ce_2M      <= (div_cnt == 5'd0) || (div_cnt == 5'd16);
      src_ready  <= 1'b0;
      frame_done <= 1'b0;
      if (load) begin
        unique case (state)
          StIdle: begin
            cnt <= 8'd0;
            if (enable && src_valid) begin
              state   <= StPre;
              bypass  <= bypass_req;
              busy    <= 1'b1;
              I       <= PRE_WORD;
              I_valid <= 1'b1;
            end else begin
              I       <= '0;
              I_valid <= 1'b0;
            end
          end
          StPre: begin
            if (cnt == PreLast) begin
              state <= StPay;
              cnt   <= 8'd0;
            end else begin
              cnt     <= cnt + 8'd1;
              I       <= PRE_WORD;
              I_valid <= 1'b1;
            end
          end
          StPay: begin
            if (pay_done == PayLen) begin
              state   <= StGap;
              cnt     <= 8'd0;
              I       <= '0;
              I_valid <= 1'b0;
            end else begin
              cnt <= pay_done;
            end
          end
          StGap: begin
            I       <= '0;
            I_valid <= 1'b0;
            if (cnt == GapLast) begin
              state      <= StIdle;
              cnt        <= 8'd0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: state <= StIdle;
        endcase

        if (pay_slot) begin
          src_ready   <= I_ready;
          cur_counted <= I_ready;
          I           <= (I_ready && src_valid) ? src_data : '0;
          I_valid     <= I_ready && src_valid;
          if (I_ready && !src_valid) begin
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flatten_frame_scheduler.sv
// Randomized bench for flatten_frame_scheduler against a symbol-level reference model
// that tracks remaining preamble/payload/gap symbols of the current frame.
module tb_flatten_frame_scheduler;

  localparam int unsigned M        = 8;
  localparam int unsigned PRE_LEN  = 8;
  localparam logic [7:0]  PRE_WORD = 8'hA5;
  localparam int unsigned PAY_LEN  = 64;
  localparam int unsigned GAP_LEN  = 4;
  localparam int          FrameCyc = (PRE_LEN + PAY_LEN + GAP_LEN + 4) * 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         bypass_req = 1'b0;
  logic [M-1:0] src_data = '0;
  logic         src_valid = 1'b0;
  logic         I_ready = 1'b1;
  logic         src_ready, ce_1M, ce_2M, bypass, I_valid, busy, frame_done, underrun;
  logic [M-1:0] I;

  flatten_frame_scheduler #(
    .M(M), .PRE_LEN(PRE_LEN), .PRE_WORD(PRE_WORD), .PAY_LEN(PAY_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bypass_req(bypass_req),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .ce_1M(ce_1M), .ce_2M(ce_2M), .bypass(bypass), .I(I), .I_valid(I_valid),
    .I_ready(I_ready), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: symbol phase plus "symbols still to send" for the active frame.
  int         m_div = 0;
  bit         m_active = 0;
  int         m_pre_left, m_pay_left, m_gap_left;
  logic       e_ce1 = 0, e_ce2 = 0, e_bypass = 0, e_valid = 0, e_ready = 0;
  logic       e_busy = 0, e_done = 0, e_under = 0;
  logic [7:0] e_I = '0;

  function automatic bit in_pay();
    return m_active && (m_pre_left == 0) && (m_pay_left > 0);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_div = 0; m_active = 0;
      {e_ce1, e_ce2, e_bypass, e_valid, e_ready, e_busy, e_done, e_under} = '0;
      e_I = '0;
    end else begin
      e_ce1 = (m_div == 0);
      e_ce2 = (m_div % 16 == 0);
      e_ready = 0;
      e_done = 0;
      if (m_div == 31) begin
        e_I = '0;
        e_valid = 0;
        if (!m_active) begin
          if (enable && src_valid) begin
            m_active = 1;
            m_pre_left = PRE_LEN - 1;
            m_pay_left = PAY_LEN;
            m_gap_left = GAP_LEN;
            e_bypass = bypass_req;
            e_busy = 1;
            e_I = PRE_WORD;
            e_valid = 1;
          end
        end else if (m_pre_left > 0) begin
          m_pre_left--;
          e_I = PRE_WORD;
          e_valid = 1;
        end else if (m_pay_left > 0) begin
          e_ready = I_ready;
          if (I_ready) begin
            m_pay_left--;
            e_valid = src_valid;
            e_I = src_valid ? src_data : 8'h00;
            if (!src_valid) e_under = 1;
          end
        end else if (m_gap_left > 0) begin
          m_gap_left--;
        end else begin
          m_active = 0;
          e_busy = 0;
          e_done = 1;
        end
      end
      m_div = (m_div + 1) % 32;
    end
  endtask

  // Advance one clock; the bench doubles as the upstream source.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (src_ready && src_valid) src_data = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    n_vec++;
    if ({ce_1M, ce_2M, bypass, I_valid, src_ready, busy, frame_done, underrun} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 00000000",
               {ce_1M, ce_2M, bypass, I_valid, src_ready, busy, frame_done, underrun});
    end
    n_vec++;
    if (I !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_I: got %h want 00", I);
    end
  endtask

  task automatic test_clock_enables();
    int n1 = 0, n2 = 0, last2 = -1;
    enable = 0;
    src_valid = 1;
    rst = 0;
    for (int c = 0; c < 96; c++) begin
      tick();
      n_vec++;
      if (ce_1M !== e_ce1 || ce_2M !== e_ce2) begin
        n_bad++;
        $display("FAIL ce_phase c=%0d: got %b%b want %b%b", c, ce_1M, ce_2M, e_ce1, e_ce2);
      end
      n_vec++;
      if (I_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_outputs c=%0d: got valid=%b busy=%b want 0 0", c, I_valid, busy);
      end
      if (ce_1M === 1'b1 && ce_2M !== 1'b1) begin
        n_vec++;
        n_bad++;
        $display("FAIL ce_coincide c=%0d: got ce_2M=%b want 1", c, ce_2M);
      end
      if (ce_2M === 1'b1) begin
        if (last2 >= 0) begin
          n_vec++;
          if (c - last2 != 16) begin
            n_bad++;
            $display("FAIL ce2_spacing: got %0d want 16", c - last2);
          end
        end
        last2 = c;
      end
      n1 += int'(ce_1M);
      n2 += int'(ce_2M);
    end
    n_vec++;
    if (n1 != 3 || n2 != 6) begin
      n_bad++;
      $display("FAIL ce_counts: got %0d/%0d want 3/6", n1, n2);
    end
  endtask

  task automatic test_full_frame();
    int pre = 0, rdy = 0, done = 0, bsy = 0;
    enable = 1; src_valid = 1; I_ready = 1;
    for (int c = 0; c < FrameCyc; c++) begin
      tick();
      if (busy) enable = 0;
      n_vec++;
      if ({I_valid, I} !== {e_valid, e_I} || src_ready !== e_ready ||
          frame_done !== e_done || busy !== e_busy) begin
        n_bad++;
        $display("FAIL frame_cycle c=%0d: got %b%h %b%b%b want %b%h %b%b%b", c, I_valid, I,
                 src_ready, frame_done, busy, e_valid, e_I, e_ready, e_done, e_busy);
      end
      if (ce_1M && busy) begin
        bsy++;
        if (I_valid && I == PRE_WORD && rdy == 0) pre++;
      end
      rdy += int'(src_ready);
      done += int'(frame_done);
    end
    n_vec++;
    if (pre != PRE_LEN || rdy != PAY_LEN || done != 1 || bsy != 76) begin
      n_bad++;
      $display("FAIL frame_totals: got pre=%0d rdy=%0d done=%0d busy=%0d want 8 64 1 76",
               pre, rdy, done, bsy);
    end
  endtask

  task automatic test_underrun();
    int holes = 0, rdy = 0, done = 0;
    n_vec++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_pre: got %b want 0", underrun);
    end
    enable = 1; I_ready = 1;
    for (int c = 0; c < FrameCyc; c++) begin
      src_valid = !(in_pay() && (m_pay_left == 40 || m_pay_left == 39));
      tick();
      if (busy) enable = 0;
      n_vec++;
      if ({I_valid, I} !== {e_valid, e_I} || underrun !== e_under) begin
        n_bad++;
        $display("FAIL underrun_cycle c=%0d: got %b%h u=%b want %b%h u=%b", c, I_valid, I,
                 underrun, e_valid, e_I, e_under);
      end
      if (src_ready && !I_valid) holes++;
      rdy += int'(src_ready);
      done += int'(frame_done);
    end
    src_valid = 1;
    n_vec++;
    if (holes != 2 || underrun !== 1'b1 || rdy != PAY_LEN || done != 1) begin
      n_bad++;
      $display("FAIL underrun_totals: got holes=%0d u=%b rdy=%0d done=%0d want 2 1 64 1",
               holes, underrun, rdy, done);
    end
  endtask

  task automatic test_stall();
    int stalls = 0, rdy = 0, bsy = 0, idle_syms = 0;
    enable = 1; src_valid = 1;
    for (int c = 0; c < FrameCyc + 3 * 32; c++) begin
      I_ready = !(in_pay() && m_pay_left == 30 && stalls < 3);
      if (m_div == 31 && !I_ready) stalls++;
      tick();
      if (busy) enable = 0;
      n_vec++;
      if ({I_valid, I} !== {e_valid, e_I} || src_ready !== e_ready) begin
        n_bad++;
        $display("FAIL stall_cycle c=%0d: got %b%h r=%b want %b%h r=%b", c, I_valid, I,
                 src_ready, e_valid, e_I, e_ready);
      end
      if (ce_1M && busy) begin
        bsy++;
        if (!I_valid) idle_syms++;
      end
      rdy += int'(src_ready);
    end
    I_ready = 1;
    n_vec++;
    if (rdy != PAY_LEN || bsy != 79 || idle_syms != 7) begin
      n_bad++;
      $display("FAIL stall_totals: got rdy=%0d busy=%0d invalid=%0d want 64 79 7",
               rdy, bsy, idle_syms);
    end
    n_vec++;
    if (underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_sticky: got %b want 1", underrun);
    end
  endtask

  task automatic test_bypass();
    logic b0;
    bit   seen_done = 0, started = 0;
    b0 = 1'($urandom);
    bypass_req = b0;
    enable = 1;
    for (int c = 0; c < FrameCyc && !seen_done; c++) begin
      if (busy && c % 37 == 0) bypass_req = ~bypass_req;
      tick();
      if (busy) begin
        enable = 0;
        started = 1;
      end
      seen_done = frame_done;
      if (started) begin
        n_vec++;
        if (bypass !== b0) begin
          n_bad++;
          $display("FAIL bypass_frozen c=%0d: got %b want %b", c, bypass, b0);
        end
      end
    end
    n_vec++;
    if (!seen_done) begin
      n_bad++;
      $display("FAIL bypass_frame_end: got no frame_done want 1");
    end
    bypass_req = ~b0;
    enable = 1;
    for (int c = 0; c < 2 * 32 && !busy; c++) tick();
    n_vec++;
    if (busy !== 1'b1 || bypass !== ~b0 || bypass !== e_bypass) begin
      n_bad++;
      $display("FAIL bypass_next: got busy=%b bypass=%b want 1 %b", busy, bypass, ~b0);
    end
    enable = 0;
    seen_done = 0;
    for (int c = 0; c < FrameCyc && !seen_done; c++) begin
      tick();
      seen_done = frame_done;
    end
  endtask

  task automatic test_reset_mid();
    int done = 0;
    bit reached = 0;
    enable = 1; src_valid = 1; I_ready = 1;
    for (int c = 0; c < FrameCyc && !reached; c++) begin
      tick();
      if (busy) enable = 0;
      reached = in_pay() && m_pay_left == 32;
    end
    n_vec++;
    if (!reached) begin
      n_bad++;
      $display("FAIL rstmid_reach: got no payload want payload");
    end
    rst = 1;
    tick();
    rst = 0;
    n_vec++;
    if ({ce_1M, ce_2M, bypass, I_valid, src_ready, busy, frame_done, underrun, I} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %b %h want all 0",
               {ce_1M, ce_2M, bypass, I_valid, src_ready, busy, frame_done, underrun}, I);
    end
    tick();
    n_vec++;
    if (ce_1M !== 1'b1 || ce_2M !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_first_ce: got %b%b want 11", ce_1M, ce_2M);
    end
    enable = 1;
    for (int c = 0; c < 40 && !busy; c++) begin
      tick();
      done += int'(frame_done);
    end
    enable = 0;
    n_vec++;
    if (busy !== 1'b1 || done != 0) begin
      n_bad++;
      $display("FAIL rstmid_restart: got busy=%b done=%0d want 1 0", busy, done);
    end
    for (int c = 0; c < FrameCyc; c++) begin
      tick();
      done += int'(frame_done);
      n_vec++;
      if ({I_valid, I} !== {e_valid, e_I} || underrun !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_frame c=%0d: got %b%h u=%b want %b%h u=0", c, I_valid, I,
                 underrun, e_valid, e_I);
      end
    end
    n_vec++;
    if (done != 1) begin
      n_bad++;
      $display("FAIL rstmid_done: got %0d want 1", done);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6000; c++) begin
      enable     = ($urandom % 4) != 0;
      src_valid  = ($urandom % 8) != 0;
      I_ready    = ($urandom % 6) != 0;
      bypass_req = 1'($urandom);
      rst        = ($urandom % 2500) == 0;
      tick();
      n_vec++;
      if ({I_valid, I} !== {e_valid, e_I}) begin
        n_bad++;
        $display("FAIL rand_sym c=%0d: got %b%h want %b%h", c, I_valid, I, e_valid, e_I);
      end
      n_vec++;
      if ({ce_1M, ce_2M, bypass, src_ready, busy, frame_done, underrun} !==
          {e_ce1, e_ce2, e_bypass, e_ready, e_busy, e_done, e_under}) begin
        n_bad++;
        $display("FAIL rand_ctl c=%0d: got %b want %b", c,
                 {ce_1M, ce_2M, bypass, src_ready, busy, frame_done, underrun},
                 {e_ce1, e_ce2, e_bypass, e_ready, e_busy, e_done, e_under});
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_clock_enables();
    test_full_frame();
    test_underrun();
    test_stall();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
